// File: rtl/hazard_ctrl.sv
// Hazard controller for the rv32i 5-stage pipeline: EX forwarding selects,
// load-use interlock with LOAD_LAT bubbles, redirect flushes, memory freeze, event counters.
module hazard_ctrl #(
    parameter int RAW      = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RAW-1:0]   src1_ID,
    input  logic [RAW-1:0]   src2_ID,
    input  logic             use1_ID,
    input  logic             use2_ID,
    input  logic [RAW-1:0]   src1_EX,
    input  logic [RAW-1:0]   src2_EX,
    input  logic [RAW-1:0]   dest_EX,
    input  logic [RAW-1:0]   dest_MEM,
    input  logic [RAW-1:0]   dest_WB,
    input  logic             regwen_EX,
    input  logic             regwen_MEM,
    input  logic             regwen_WB,
    input  logic             memread_EX,
    input  logic             PCsel_EX,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LDUSE   = 2'd1;
    localparam logic [1:0] MEMWAIT = 2'd2;

    localparam logic [1:0] BCNT_INIT = 2'(LOAD_LAT - 1);
    localparam bit         MULTI     = (LOAD_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [1:0]       ret_r;
    logic [1:0]       bcnt_r;
    logic [1:0]       state_nxt_s;
    logic [1:0]       ret_nxt_s;
    logic [1:0]       bcnt_nxt_s;
    logic [1:0]       eff_s;
    logic             lu_s;
    logic             flush_ev_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // MEM result has priority over WB; x0 is never forwarded
    function automatic logic [1:0] fwd_sel(
        input logic [RAW-1:0] src,
        input logic           wen_m,
        input logic [RAW-1:0] dst_m,
        input logic           wen_w,
        input logic [RAW-1:0] dst_w
    );
        if (wen_m && (dst_m != {RAW{1'b0}}) && (dst_m == src)) begin
            fwd_sel = 2'b10;
        end else if (wen_w && (dst_w != {RAW{1'b0}}) && (dst_w == src)) begin
            fwd_sel = 2'b11;
        end else begin
            fwd_sel = 2'b00;
        end
    endfunction

    // MEMWAIT behaves as the state it froze
    assign eff_s = (state_r == MEMWAIT) ? ret_r : state_r;

    // Load-use detection and forwarding selects
    always_comb begin
        lu_s = memread_EX && regwen_EX && (dest_EX != {RAW{1'b0}}) &&
               ((use1_ID && (src1_ID == dest_EX)) || (use2_ID && (src2_ID == dest_EX)));
        if (rst) begin
            fwdA = 2'b00;
            fwdB = 2'b00;
        end else begin
            fwdA = fwd_sel(src1_EX, regwen_MEM, dest_MEM, regwen_WB, dest_WB);
            fwdB = fwd_sel(src2_EX, regwen_MEM, dest_MEM, regwen_WB, dest_WB);
        end
    end

    // Pipeline stall/flush controls, priority: reset, freeze, redirect, interlock
    always_comb begin
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        stall_E    = 1'b0;
        stall_M    = 1'b0;
        flush_D    = 1'b0;
        flush_E    = 1'b0;
        flush_ev_s = 1'b0;
        if (rst) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (mem_busy) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
        end else if (PCsel_EX) begin
            flush_D    = 1'b1;
            flush_E    = 1'b1;
            flush_ev_s = 1'b1;
        end else if ((eff_s == LDUSE) || lu_s) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end else begin
            flush_ev_s = 1'b0;
        end
    end

    // Next-state logic; the return state and bcnt are held while memory is busy
    always_comb begin
        state_nxt_s = IDLE;
        ret_nxt_s   = ret_r;
        bcnt_nxt_s  = bcnt_r;
        if (mem_busy) begin
            state_nxt_s = MEMWAIT;
            ret_nxt_s   = eff_s;
        end else if (PCsel_EX) begin
            state_nxt_s = IDLE;
            bcnt_nxt_s  = 2'd0;
        end else if (eff_s == LDUSE) begin
            if (bcnt_r == 2'd1) begin
                state_nxt_s = IDLE;
                bcnt_nxt_s  = 2'd0;
            end else begin
                state_nxt_s = LDUSE;
                bcnt_nxt_s  = bcnt_r - 2'd1;
            end
        end else if (lu_s && MULTI) begin
            state_nxt_s = LDUSE;
            bcnt_nxt_s  = BCNT_INIT;
        end else begin
            state_nxt_s = IDLE;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ret_r   <= IDLE;
            bcnt_r  <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            ret_r   <= ret_nxt_s;
            bcnt_r  <= bcnt_nxt_s;
        end
    end

    // Performance counters; clear wins over increment, wrap is natural
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_D) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (flush_ev_s) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three builds (LOAD_LAT=1, LOAD_LAT=3, CNT_W=4)
// share stimulus; the driver queues expectations, a negedge monitor compares.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] src1_ID, src2_ID, src1_EX, src2_EX, dest_EX, dest_MEM, dest_WB;
    logic       use1_ID, use2_ID, regwen_EX, regwen_MEM, regwen_WB;
    logic       memread_EX, PCsel_EX, mem_busy, cnt_clr;

    logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2;
    logic        sf0, sd0, se0, sm0, fd0, fe0;
    logic        sf1, sd1, se1, sm1, fd1, fe1;
    logic        sf2, sd2, se2, sm2, fd2, fe2;
    logic [31:0] sc0, fc0, sc1, fc1;
    logic [3:0]  sc2, fc2;

    typedef struct packed {
        logic [1:0]  sel;
        logic [2:0]  mask;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [3:0]  st;
        logic [1:0]  fl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.RAW(5), .LOAD_LAT(1), .CNT_W(32)) u_lat1 (
        .clk(clk), .rst(rst), .src1_ID(src1_ID), .src2_ID(src2_ID), .use1_ID(use1_ID), .use2_ID(use2_ID),
        .src1_EX(src1_EX), .src2_EX(src2_EX), .dest_EX(dest_EX), .dest_MEM(dest_MEM), .dest_WB(dest_WB),
        .regwen_EX(regwen_EX), .regwen_MEM(regwen_MEM), .regwen_WB(regwen_WB), .memread_EX(memread_EX),
        .PCsel_EX(PCsel_EX), .mem_busy(mem_busy), .cnt_clr(cnt_clr), .fwdA(fa0), .fwdB(fb0),
        .stall_F(sf0), .stall_D(sd0), .stall_E(se0), .stall_M(sm0), .flush_D(fd0), .flush_E(fe0),
        .stall_cnt(sc0), .flush_cnt(fc0));

    hazard_ctrl #(.RAW(5), .LOAD_LAT(3), .CNT_W(32)) u_lat3 (
        .clk(clk), .rst(rst), .src1_ID(src1_ID), .src2_ID(src2_ID), .use1_ID(use1_ID), .use2_ID(use2_ID),
        .src1_EX(src1_EX), .src2_EX(src2_EX), .dest_EX(dest_EX), .dest_MEM(dest_MEM), .dest_WB(dest_WB),
        .regwen_EX(regwen_EX), .regwen_MEM(regwen_MEM), .regwen_WB(regwen_WB), .memread_EX(memread_EX),
        .PCsel_EX(PCsel_EX), .mem_busy(mem_busy), .cnt_clr(cnt_clr), .fwdA(fa1), .fwdB(fb1),
        .stall_F(sf1), .stall_D(sd1), .stall_E(se1), .stall_M(sm1), .flush_D(fd1), .flush_E(fe1),
        .stall_cnt(sc1), .flush_cnt(fc1));

    hazard_ctrl #(.RAW(5), .LOAD_LAT(1), .CNT_W(4)) u_w4 (
        .clk(clk), .rst(rst), .src1_ID(src1_ID), .src2_ID(src2_ID), .use1_ID(use1_ID), .use2_ID(use2_ID),
        .src1_EX(src1_EX), .src2_EX(src2_EX), .dest_EX(dest_EX), .dest_MEM(dest_MEM), .dest_WB(dest_WB),
        .regwen_EX(regwen_EX), .regwen_MEM(regwen_MEM), .regwen_WB(regwen_WB), .memread_EX(memread_EX),
        .PCsel_EX(PCsel_EX), .mem_busy(mem_busy), .cnt_clr(cnt_clr), .fwdA(fa2), .fwdB(fb2),
        .stall_F(sf2), .stall_D(sd2), .stall_E(se2), .stall_M(sm2), .flush_D(fd2), .flush_E(fe2),
        .stall_cnt(sc2), .flush_cnt(fc2));

    task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, got, exp);
        end
    endtask

    // Monitor: one queued expectation per sampled cycle, mask bits = {cnt, ctl, fwd}
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            string       nm;
            logic [1:0]  fa, fb, fl;
            logic [3:0]  st;
            logic [31:0] sc, fc;
            e  = q.pop_front();
            nm = nq.pop_front();
            case (e.sel)
                2'd0: begin fa = fa0; fb = fb0; st = {sf0, sd0, se0, sm0}; fl = {fd0, fe0}; sc = sc0; fc = fc0; end
                2'd1: begin fa = fa1; fb = fb1; st = {sf1, sd1, se1, sm1}; fl = {fd1, fe1}; sc = sc1; fc = fc1; end
                default: begin fa = fa2; fb = fb2; st = {sf2, sd2, se2, sm2}; fl = {fd2, fe2};
                               sc = {28'd0, sc2}; fc = {28'd0, fc2}; end
            endcase
            if (e.mask[0]) begin
                cmp(nm, "fwdA", {30'd0, fa}, {30'd0, e.fa});
                cmp(nm, "fwdB", {30'd0, fb}, {30'd0, e.fb});
            end
            if (e.mask[1]) begin
                cmp(nm, "stall_FDEM", {28'd0, st}, {28'd0, e.st});
                cmp(nm, "flush_DE", {30'd0, fl}, {30'd0, e.fl});
            end
            if (e.mask[2]) begin
                cmp(nm, "stall_cnt", sc, e.sc);
                cmp(nm, "flush_cnt", fc, e.fc);
            end
        end
    end

    task automatic push(input string nm, input logic [1:0] sel, input logic [2:0] mask,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] st,
                        input logic [1:0] fl, input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        e.sel = sel; e.mask = mask; e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.sc = sc; e.fc = fc;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src1_ID = 5'd0; src2_ID = 5'd0; use1_ID = 1'b0; use2_ID = 1'b0;
        src1_EX = 5'd0; src2_EX = 5'd0; dest_EX = 5'd0; dest_MEM = 5'd0; dest_WB = 5'd0;
        regwen_EX = 1'b0; regwen_MEM = 1'b0; regwen_WB = 1'b0;
        memread_EX = 1'b0; PCsel_EX = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
    endtask

    // Load in EX writing x7, ID instruction reads x7 via rs2
    task automatic hazard();
        memread_EX = 1'b1; regwen_EX = 1'b1; dest_EX = 5'd7; src2_ID = 5'd7; use2_ID = 1'b1;
    endtask

    // Bubble in EX after the interlock
    task automatic bubble();
        memread_EX = 1'b0; regwen_EX = 1'b0; dest_EX = 5'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        // Reset state, with a would-be MEM forward present
        src1_EX = 5'd5; dest_MEM = 5'd5; regwen_MEM = 1'b1;
        push("reset", 2'd0, 3'b111, 2'b00, 2'b00, 4'b0000, 2'b11, 32'd0, 32'd0);
        tick();
        rst = 1'b0;

        // Forwarding priority
        src1_EX = 5'd5; src2_EX = 5'd3; dest_MEM = 5'd5; regwen_MEM = 1'b1; dest_WB = 5'd5; regwen_WB = 1'b1;
        push("fwd_mem_prio", 2'd0, 3'b111, 2'b10, 2'b00, 4'b0000, 2'b00, 32'd0, 32'd0);
        tick();
        regwen_MEM = 1'b0;
        push("fwd_wb", 2'd0, 3'b111, 2'b11, 2'b00, 4'b0000, 2'b00, 32'd0, 32'd0);
        tick();
        regwen_MEM = 1'b1; dest_MEM = 5'd3;
        push("fwd_split", 2'd0, 3'b111, 2'b11, 2'b10, 4'b0000, 2'b00, 32'd0, 32'd0);
        tick();
        dest_MEM = 5'd0; dest_WB = 5'd0; src1_EX = 5'd0; src2_EX = 5'd0;
        push("fwd_x0", 2'd0, 3'b111, 2'b00, 2'b00, 4'b0000, 2'b00, 32'd0, 32'd0);
        tick();
        clear_inputs();

        // LOAD_LAT=1: one bubble, then self-clear
        hazard();
        push("lat1_stall", 2'd0, 3'b110, 2'b00, 2'b00, 4'b1100, 2'b01, 32'd0, 32'd0);
        tick();
        bubble();
        push("lat1_release", 2'd0, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b00, 32'd1, 32'd0);
        tick();
        // lu together with redirect: flush only, no stall counted
        hazard(); PCsel_EX = 1'b1;
        push("lu_redirect", 2'd0, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b11, 32'd1, 32'd0);
        tick();
        clear_inputs();
        push("lu_redirect_after", 2'd0, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b00, 32'd1, 32'd1);
        tick();

        // LOAD_LAT=3: three bubbles
        do_reset();
        hazard();
        push("lat3_b1", 2'd1, 3'b110, 2'b00, 2'b00, 4'b1100, 2'b01, 32'd0, 32'd0);
        tick();
        bubble();
        push("lat3_b2", 2'd1, 3'b110, 2'b00, 2'b00, 4'b1100, 2'b01, 32'd1, 32'd0);
        tick();
        push("lat3_b3", 2'd1, 3'b110, 2'b00, 2'b00, 4'b1100, 2'b01, 32'd2, 32'd0);
        tick();
        push("lat3_idle", 2'd1, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b00, 32'd3, 32'd0);
        tick();
        hazard(); use2_ID = 1'b0;
        push("lat3_nouse", 2'd1, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b00, 32'd3, 32'd0);
        tick();
        push("lat3_nouse2", 2'd1, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b00, 32'd3, 32'd0);
        tick();

        // Redirect in the second bubble cycle
        do_reset();
        hazard();
        push("rd_b1", 2'd1, 3'b110, 2'b00, 2'b00, 4'b1100, 2'b01, 32'd0, 32'd0);
        tick();
        bubble(); PCsel_EX = 1'b1;
        push("rd_flush", 2'd1, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b11, 32'd1, 32'd0);
        tick();
        PCsel_EX = 1'b0;
        push("rd_idle", 2'd1, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b00, 32'd1, 32'd1);
        tick();

        // mem_busy freeze in LDUSE with bcnt=2 and a pending redirect
        do_reset();
        hazard();
        push("busy_b1", 2'd1, 3'b110, 2'b00, 2'b00, 4'b1100, 2'b01, 32'd0, 32'd0);
        tick();
        bubble(); mem_busy = 1'b1; PCsel_EX = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push("busy_freeze", 2'd1, 3'b110, 2'b00, 2'b00, 4'b1111, 2'b00, 32'(i + 1), 32'd0);
            tick();
        end
        mem_busy = 1'b0;
        push("busy_redirect", 2'd1, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b11, 32'd5, 32'd0);
        tick();
        PCsel_EX = 1'b0;
        push("busy_after", 2'd1, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b00, 32'd5, 32'd1);
        tick();

        // Reset in the middle of LDUSE
        hazard();
        push("rstmid_b1", 2'd1, 3'b110, 2'b00, 2'b00, 4'b1100, 2'b01, 32'd5, 32'd1);
        tick();
        bubble(); rst = 1'b1;
        push("rstmid_rst", 2'd1, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b11, 32'd6, 32'd1);
        tick();
        rst = 1'b0;
        push("rstmid_idle", 2'd1, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b00, 32'd0, 32'd0);
        tick();

        // CNT_W=4 wrap after 17 stall cycles, then clear beats increment
        do_reset();
        memread_EX = 1'b1; regwen_EX = 1'b1; dest_EX = 5'd9; src1_ID = 5'd9; use1_ID = 1'b1;
        for (int k = 0; k < 17; k++) begin
            push("wrap_stall", 2'd2, 3'b110, 2'b00, 2'b00, 4'b1100, 2'b01, 32'(k % 16), 32'd0);
            tick();
        end
        bubble();
        push("wrap_value", 2'd2, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b00, 32'd1, 32'd0);
        tick();
        memread_EX = 1'b1; regwen_EX = 1'b1; dest_EX = 5'd9; cnt_clr = 1'b1;
        push("clr_cycle", 2'd2, 3'b110, 2'b00, 2'b00, 4'b1100, 2'b01, 32'd1, 32'd0);
        tick();
        bubble(); cnt_clr = 1'b0;
        push("clr_zero", 2'd2, 3'b110, 2'b00, 2'b00, 4'b0000, 2'b00, 32'd0, 32'd0);
        tick();

        for (int w = 0; w < 10 && q.size() > 0; w++) begin
            tick();
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1);
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the rv32i 5-stage pipeline. It generates the EX operand forwarding selects, a load-use interlock with a configurable number of bubbles, and branch/jump redirect flushes. It also freezes the whole pipeline while data memory is busy, and keeps registered stall and flush event counters for performance analysis. It sits beside the pipeline registers and drives their stall and flush controls.

## Interface
- RAW, 5: register-address width.
- LOAD_LAT, 1: bubbles inserted per load-use hazard. Legal range 1..4.
- CNT_W, 32: width of the performance counters.

- clk  in  1  clock. Reset is synchronous and active-high, sampled on the clk rising edge.
- rst  in  1  synchronous active-high reset.
- src1_ID, src2_ID  in  RAW  rs1/rs2 of the instruction in ID.
- use1_ID, use2_ID  in  1  the ID instruction actually reads rs1/rs2.
- src1_EX, src2_EX  in  RAW  rs1/rs2 of the instruction in EX.
- dest_EX, dest_MEM, dest_WB  in  RAW  rd of the instruction in each stage.
- regwen_EX, regwen_MEM, regwen_WB  in  1  that stage writes rd.
- memread_EX  in  1  EX holds a load.
- PCsel_EX  in  1  redirect (taken branch/JAL/JALR) resolved in EX.
- mem_busy  in  1  data memory not ready; MEM stage cannot complete.
- cnt_clr  in  1  synchronous clear of both counters.
- fwdA, fwdB  out  2  EX operand source: 00 register file, 10 MEM result, 11 WB result.
- stall_F, stall_D, stall_E, stall_M  out  1  hold the PC/IF-ID/ID-EX/EX-MEM registers.
- flush_D, flush_E  out  1  load a bubble into IF-ID/ID-EX.
- stall_cnt, flush_cnt  out  CNT_W  event counters.

## Operation
- Forwarding is combinational. fwdA=10 if regwen_MEM & dest_MEM!=0 & dest_MEM==src1_EX. Otherwise fwdA=11 if regwen_WB & dest_WB!=0 & dest_WB==src1_EX. Otherwise fwdA=00.
- MEM has priority over WB. fwdB is computed the same way on src2_EX. x0 is never forwarded.
- Load-use hazard (lu) is asserted when all of the following hold:
  - memread_EX & regwen_EX & dest_EX!=0;
  - (use1_ID & src1_ID==dest_EX) | (use2_ID & src2_ID==dest_EX).
- FSM states are IDLE, LDUSE and MEMWAIT. The 2-bit bubble counter is bcnt.
- IDLE:
  - If lu: stall_F=stall_D=1 and flush_E=1.
  - If lu and LOAD_LAT>1: next state LDUSE, bcnt<=LOAD_LAT-1.
- LDUSE:
  - stall_F=stall_D=flush_E=1.
  - bcnt decrements each non-busy cycle. When bcnt==1, next state IDLE.
  - The total is exactly LOAD_LAT bubbles per hazard.
- Redirect: PCsel_EX forces flush_D=flush_E=1 and clears stall_F/stall_D. The PC takes the target.
  - Redirect overrides lu and LDUSE: next state IDLE, bcnt<=0.
- mem_busy has the highest priority:
  - stall_F=stall_D=stall_E=stall_M=1 and flush_D=flush_E=0. State is MEMWAIT.
  - The return state and bcnt are held. The redirect stays pending because PCsel_EX stays asserted while EX is frozen.
  - On the first cycle after mem_busy drops, the FSM resumes the held state and evaluates redirect/lu normally.
- Counters:
  - stall_cnt += 1 each cycle stall_D=1.
  - flush_cnt += 1 each cycle a redirect flush is issued.
  - Both wrap modulo 2^CNT_W. cnt_clr zeroes both and has priority over increment.

## Timing
- All forwarding, stall and flush outputs are combinational from the current state and inputs. There is zero-cycle latency to the pipeline registers.
- State, bcnt and the counters update on the clk rising edge.
- While rst=1:
  - fwdA=fwdB=00, all stall_*=0, flush_D=flush_E=1.
  - Next state IDLE, bcnt=0, stall_cnt=flush_cnt=0.
- Reset in LDUSE or MEMWAIT abandons the sequence. The first cycle after reset is IDLE.
- The dependent instruction leaves ID exactly LOAD_LAT cycles (excluding busy cycles) after lu is first seen.
- With LOAD_LAT=1 no LDUSE cycle occurs. The bubble now in EX has regwen_EX=0, so lu self-clears.
- lu and PCsel_EX in the same cycle: flushes only, zero stall cycles counted.
- mem_busy, PCsel_EX and lu in the same cycle: freeze only. Counters do not count flushes. stall_cnt does count, since stall_D=1.

## Test plan
- Forwarding priority:
  - Stimulus: src1_EX=5, dest_MEM=5, regwen_MEM=1, dest_WB=5, regwen_WB=1.
  - Required: fwdA=10. Dropping regwen_MEM gives fwdA=11. dest_MEM=dest_WB=0 with src1_EX=0 gives fwdA=00.
- Load-use with LOAD_LAT=1:
  - Stimulus: memread_EX=1, regwen_EX=1, dest_EX=7, src2_ID=7, use2_ID=1.
  - Required: one cycle of stall_F=stall_D=flush_E=1, then release. stall_cnt=1.
- LOAD_LAT=3 build, same hazard:
  - Required: exactly 3 consecutive stall/flush_E cycles, state IDLE afterwards, stall_cnt=3.
  - Repeat with use2_ID=0: no stall.
- Redirect during LDUSE (LOAD_LAT=3):
  - Stimulus: assert PCsel_EX in the 2nd bubble cycle.
  - Required: flush_D=flush_E=1, stall_D=0 that cycle, IDLE next cycle, flush_cnt=1.
- mem_busy freeze:
  - Stimulus: in LDUSE with bcnt=2, hold mem_busy for 4 cycles with PCsel_EX=1.
  - Required: all stalls=1 and flushes=0 for 4 cycles. Redirect flush fires on the 5th cycle.
- Reset mid-sequence and counter wrap:
  - Stimulus: rst in LDUSE.
  - Required: the next cycle is IDLE with counters 0.
  - Stimulus: CNT_W=4 build, 17 stall cycles. Required: stall_cnt=1. cnt_clr zeroes it.
